// File: rtl/ula_sum_capture.sv
// ula_sum_capture: registered result stage behind the ALU adder; stores sum + flags in a FIFO
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sum_i [WIDTH:0]     adder sum, bit WIDTH is carry-out
//   a_msb_i, b_msb_i    operand sign bits used for signed overflow
//   in_valid/in_ready   producer handshake (in_ready = not full)
//   clear               synchronous flush, overrides push and pop
//   out_data/out_*      head entry result and flags, zero when empty
//   out_valid/out_ready consumer handshake
//   count               entries held
//
// Build option: define SUM_SATURATE_EN to clamp overflowing results to the signed limit.
module ula_sum_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH:0]             sum_i,
    input  logic                       a_msb_i,
    input  logic                       b_msb_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clear,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_carry,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 4;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;
    logic             carry, zero, neg, ovf;
    logic [WIDTH-1:0] data;
    logic [EW-1:0]    head;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign carry = sum_i[WIDTH];
    assign zero  = (sum_i[WIDTH-1:0] == '0);
    assign neg   = sum_i[WIDTH-1];
    assign ovf   = (a_msb_i == b_msb_i) & (sum_i[WIDTH-1] != a_msb_i);

`ifdef SUM_SATURATE_EN
    // Overflow direction follows the common operand sign: positive clamps high, negative low.
    assign data = ovf ? (a_msb_i ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                      : sum_i[WIDTH-1:0];
`else
    assign data = sum_i[WIDTH-1:0];
`endif

    // Storage needs no reset: count gates everything visible on the outputs.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= {carry, zero, neg, ovf, data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            count  <= count + CW'(push) - CW'(pop);
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_carry, out_zero, out_neg, out_ovf, out_data} = head;
endmodule

// File: tb/tb_ula_sum_capture.sv
// tb_ula_sum_capture: directed self-checking bench for ula_sum_capture
module tb_ula_sum_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] sum_i = '0;
    logic       a_msb_i = 1'b0, b_msb_i = 1'b0;
    logic       in_valid = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_carry, out_zero, out_neg, out_ovf, out_valid;
    logic [7:0] out_data;
    logic [1:0] count;
    logic [12:0] obs;
    int checks = 0;
    int errors = 0;

`ifdef SUM_SATURATE_EN
    localparam logic [7:0] D2C = 8'h80, D100 = 8'h80, D080 = 8'h7F;
`else
    localparam logic [7:0] D2C = 8'h2C, D100 = 8'h00, D080 = 8'h80;
`endif

    ula_sum_capture #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .sum_i(sum_i), .a_msb_i(a_msb_i), .b_msb_i(b_msb_i),
        .in_valid(in_valid), .in_ready(in_ready), .clear(clear), .out_data(out_data),
        .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    // {valid, carry, zero, neg, ovf, data}
    assign obs = {out_valid, out_carry, out_zero, out_neg, out_ovf, out_data};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] s, input logic a, input logic b);
        in_valid = v; sum_i = s; a_msb_i = a; b_msb_i = b;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL reset_out obs=%h exp=0", obs); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        #12 rst_n = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(1, 9'h011, 0, 0); tick();
        drive(1, 9'h022, 0, 0); tick();
        drive(0, 9'h000, 0, 0);
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL midreset_fill got=%0d exp=2", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL midreset_count got=%0d exp=0", count); end
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL midreset_out obs=%h exp=0", obs); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL post_reset_stale obs=%h exp=0", obs); end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(1, 9'h12C, 1, 1); tick();
        drive(0, 9'h000, 0, 0);
        checks++; if (obs !== {5'b11001, D2C}) begin errors++; $display("FAIL flags_12c obs=%h exp=%h", obs, {5'b11001, D2C}); end
        tick();
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL flags_drain obs=%h exp=0", obs); end
        drive(1, 9'h100, 1, 1); tick();
        checks++; if (obs !== {5'b11101, D100}) begin errors++; $display("FAIL flags_100 obs=%h exp=%h", obs, {5'b11101, D100}); end
        drive(1, 9'h07F, 0, 0); tick();
        checks++; if (obs !== {5'b10000, 8'h7F}) begin errors++; $display("FAIL flags_07f obs=%h exp=%h", obs, {5'b10000, 8'h7F}); end
        drive(1, 9'h080, 0, 0); tick();
        checks++; if (obs !== {5'b10011, D080}) begin errors++; $display("FAIL flags_080 obs=%h exp=%h", obs, {5'b10011, D080}); end
        drive(1, 9'h0F0, 0, 1); tick();
        checks++; if (obs !== {5'b10010, 8'hF0}) begin errors++; $display("FAIL flags_0f0 obs=%h exp=%h", obs, {5'b10010, 8'hF0}); end
        drive(0, 9'h000, 0, 0); tick();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL flags_empty got=%0d exp=0", count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1, 9'h011, 0, 0); tick();
        drive(1, 9'h022, 0, 0); tick();
        drive(1, 9'h033, 0, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_full_count got=%0d exp=2", count); end
        tick();
        checks++; if (count !== 2'd2 || out_data !== 8'h11) begin errors++; $display("FAIL bp_hold count=%0d data=%h exp=2,11", count, out_data); end
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 2'd1 || out_data !== 8'h22 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1 count=%0d data=%h rdy=%b exp=1,22,1", count, out_data, in_ready); end
        tick();
        drive(0, 9'h000, 0, 0);
        checks++; if (count !== 2'd1 || out_data !== 8'h33) begin errors++; $display("FAIL bp_pop2 count=%0d data=%h exp=1,33", count, out_data); end
        tick();
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain count=%0d valid=%b exp=0,0", count, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [5];
        vals = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        out_ready = 1'b0;
        drive(1, 9'h011, 0, 0); tick();
        checks++; if (count !== 2'd1 || out_data !== 8'h11) begin errors++; $display("FAIL b2b_start count=%0d data=%h exp=1,11", count, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, {1'b0, vals[i]}, 0, 0); tick();
            checks++; if (count !== 2'd1 || out_data !== vals[i]) begin errors++; $display("FAIL b2b_%0d count=%0d data=%h exp=1,%h", i, count, out_data, vals[i]); end
        end
        drive(0, 9'h000, 0, 0); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain valid=%b exp=0", out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        drive(1, 9'h0AA, 0, 0); tick();
        drive(1, 9'h0BB, 0, 0); tick();
        drive(1, 9'h0CC, 0, 0); clear = 1'b1; out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
        tick();
        clear = 1'b0; drive(0, 9'h000, 0, 0);
        checks++; if (count !== 2'd0 || obs !== 13'h0) begin errors++; $display("FAIL clear_full count=%0d obs=%h exp=0,0", count, obs); end
        tick();
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL clear_stale obs=%h exp=0", obs); end
        out_ready = 1'b0;
        drive(1, 9'h0DD, 0, 0); tick();
        drive(1, 9'h0EE, 0, 0); clear = 1'b1; out_ready = 1'b1; tick();
        clear = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clear_pushpop count=%0d valid=%b exp=0,0", count, out_valid); end
        drive(1, 9'h0FF, 0, 0); out_ready = 1'b0; tick();
        drive(0, 9'h000, 0, 0);
        checks++; if (count !== 2'd1 || out_data !== 8'hFF) begin errors++; $display("FAIL clear_after count=%0d data=%h exp=1,ff", count, out_data); end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
